// File: rtl/gate_bist_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gate_bist_pkg
// Brief   : Op encodings, FSM state encoding and truth-table helpers for the
//           2-input gate BIST sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package gate_bist_pkg;

    localparam logic [2:0] c_op_and  = 3'b000;
    localparam logic [2:0] c_op_or   = 3'b001;
    localparam logic [2:0] c_op_nand = 3'b010;
    localparam logic [2:0] c_op_nor  = 3'b011;
    localparam logic [2:0] c_op_xor  = 3'b100;
    localparam logic [2:0] c_op_xnor = 3'b101;

    typedef enum logic [1:0] {
        c_st_idle  = 2'd0,
        c_st_apply = 2'd1,
        c_st_done  = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= c_op_xnor);
    endfunction

    function automatic logic expected(input logic [2:0] op, input logic a, input logic b);
        logic y;
        y = 1'b0;
        case (op)
            c_op_and:  y = a & b;
            c_op_or:   y = a | b;
            c_op_nand: y = ~(a & b);
            c_op_nor:  y = ~(a | b);
            c_op_xor:  y = a ^ b;
            c_op_xnor: y = ~(a ^ b);
            default:   y = 1'b0;
        endcase
        return y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_ref_model.sv
`default_nettype none
// ============================================================================
// Module  : gate_ref_model
// Brief   : Combinational golden model of the 2-input gate library.
// Rev     : 1.0  initial release
// ============================================================================
module gate_ref_model
    import gate_bist_pkg::*;
(
    input  logic [2:0] op,
    input  logic       a,
    input  logic       b,
    output logic       exp_y,
    output logic       op_legal
);

    always_comb begin
        exp_y    = expected(op, a, b);
        op_legal = op_is_legal(op);
    end

endmodule
`default_nettype wire

// File: rtl/gate_bist.sv
`default_nettype none
// ============================================================================
// Module  : gate_bist
// Brief   : Exhaustive 4-vector self-test sequencer for a 2-input gate.
// Rev     : 1.0  initial release
// ============================================================================
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    output logic             dut_a,
    output logic             dut_b,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [3:0]       fail_vec
);

    localparam int                 c_cnt_w    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(HOLD_CYCLES - 1);
    localparam logic [ERR_W-1:0]   c_err_max  = '1;
    localparam logic [ERR_W-1:0]   c_err_rsv  = (ERR_W >= 3) ? ERR_W'(4) : c_err_max;

    state_t             r_state, w_state;
    logic [2:0]         r_op, w_op;
    logic [c_cnt_w-1:0] r_cnt, w_cnt;
    logic [1:0]         r_idx, w_idx;
    logic               r_a, w_a;
    logic               r_b, w_b;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_pass, w_pass;
    logic [ERR_W-1:0]   r_err, w_err;
    logic [3:0]         r_fv, w_fv;

    logic [2:0]         w_model_op;
    logic               w_exp_y;
    logic               w_op_legal;

    // In IDLE the model judges the incoming op; afterwards only the latched op matters.
    assign w_model_op = (r_state == c_st_idle) ? op : r_op;

    gate_ref_model u_ref (
        .op       (w_model_op),
        .a        (r_a),
        .b        (r_b),
        .exp_y    (w_exp_y),
        .op_legal (w_op_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_op    <= 3'b000;
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_fv    <= 4'b0000;
        end else begin
            r_state <= w_state;
            r_op    <= w_op;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
            r_fv    <= w_fv;
        end
    end

    always_comb begin
        w_state = r_state;
        w_op    = r_op;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_a     = r_a;
        w_b     = r_b;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_pass  = r_pass;
        w_err   = r_err;
        w_fv    = r_fv;

        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_op   = op;
                    w_cnt  = '0;
                    w_idx  = 2'd0;
                    w_a    = 1'b0;
                    w_b    = 1'b0;
                    w_busy = 1'b1;
                    w_pass = 1'b0;
                    if (w_op_legal) begin
                        w_state = c_st_apply;
                        w_err   = '0;
                        w_fv    = 4'b0000;
                    end else begin
                        w_state = c_st_done;
                        w_err   = c_err_rsv;
                        w_fv    = 4'b1111;
                    end
                end
            end

            c_st_apply: begin
                if (r_cnt == c_cnt_last) begin
                    w_cnt = '0;
                    if (dut_y != w_exp_y) begin
                        w_fv[r_idx] = 1'b1;
                        if (r_err != c_err_max) begin
                            w_err = r_err + 1'b1;
                        end
                    end
                    if (r_idx == 2'd3) begin
                        w_state = c_st_done;
                        w_done  = 1'b1;
                        w_pass  = (w_fv == 4'b0000);
                    end else begin
                        w_idx        = r_idx + 2'd1;
                        {w_a, w_b}   = r_idx + 2'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end

            c_st_done: begin
                // A reserved-op run enters DONE without the pulse and raises it one cycle later.
                if (!r_done) begin
                    w_done = 1'b1;
                    w_pass = (r_fv == 4'b0000);
                end else begin
                    w_state = c_st_idle;
                    w_busy  = 1'b0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                end
            end

            default: begin
                w_state = c_st_idle;
            end
        endcase
    end

    assign dut_a    = r_a;
    assign dut_b    = r_b;
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err;
    assign fail_vec = r_fv;

endmodule
`default_nettype wire
